serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Bit-serial N-bit adder datapath and controller around one 1-bit full-adder cell.
//  Captures operands on a start pulse and feeds the cell one bit per clock, LSB first.
//  Carries the cell's carry-out back in through a flip-flop and assembles the sum word.
//  Sits between the operand source and the result consumer: a low-area alternative to a ripple adder.
// PARAMETERS
//  WIDTH   8   operand/sum width in bits; legal range 2..64
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only when ready=1
//  a       in   WIDTH  operand A, captured on accepted start
//  b       in   WIDTH  operand B, captured on accepted start
//  cin     in   1      carry-in, captured on accepted start
//  ready   out  1      1 = start will be accepted this cycle
//  busy    out  1      1 = addition in progress (SHIFT state)
//  done    out  1      one-cycle pulse: sum/cout valid and newly updated
//  sum     out  WIDTH  result; holds its value until the next completion
//  cout    out  1      final carry; holds like sum
// BEHAVIOUR
//  - One clock; reset is asynchronous, active-low. rst_n=0 immediately forces:
//    - state=IDLE and ready=1;
//    - busy=0, done=0;
//    - sum=0, cout=0, all internal shift/carry/count registers to 0.
//  - FSM states IDLE, SHIFT, DONE (2-bit encoding); ready = (state!=SHIFT).
//  - IDLE, start=1: a_sr<=a; b_sr<=b; carry<=cin; cnt<=0; next state SHIFT.
//  - SHIFT, every cycle, the cell computes {c,s} = a_sr[0]+b_sr[0]+carry. Then:
//    - a_sr, b_sr shift right by 1;
//    - acc <= {s, acc[WIDTH-1:1]};
//    - carry <= c; cnt <= cnt+1.
//  - SHIFT exit: when cnt==WIDTH-1, do that cycle's shift, then:
//    - sum <= {s, acc[WIDTH-1:1]}; cout <= c;
//    - next state DONE.
//  - DONE: done=1 for exactly this cycle; always exit.
//    - start=1: identical capture to IDLE, next state SHIFT (back-to-back).
//    - otherwise next state IDLE.
//  - Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH.
//    - throughput: one result per WIDTH+1 cycles.
//  - start while busy=1: ignored; no effect on operands, count or outputs.
//  - Operands a, b, cin are don't-care except in the accept cycle.
//  - Arithmetic: {cout,sum} = a + b + cin modulo 2^(WIDTH+1); no overflow flag.
//  - sum/cout change only on the completion edge (or reset): never show partial results.
//  - Reset mid-SHIFT: abort; no done pulse; outputs return to reset values.
//  - cnt width is $clog2(WIDTH); cnt wraps to 0 at each new capture.
// STRUCTURE
//  - Package serial_adder_pkg holds:
//    - state typedef/localparams S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2;
//    - function cnt_w(WIDTH) returning $clog2(WIDTH).
//  - One sub-module: fa_cell, gate-level 1-bit full adder, ports (s,c,a,b,cin).
//    - instantiated exactly once; purely combinational.
//  - Top level holds the FSM, a_sr/b_sr/acc shift registers, the carry FF, cnt, and the sum/cout registers.
// TESTING
//  - Run all cases at WIDTH=8 unless noted; the scoreboard compares {cout,sum} to a+b+cin.
//  - 0x5A+0x3C, cin=0, single start -> done 9 cycles after accept; sum=0x96, cout=0.
//  - 0xFF+0x01, cin=0 -> sum=0x00, cout=1; 0xFF+0xFF, cin=1 -> sum=0xFF, cout=1.
//  - start re-pulsed with 0x11+0x22 mid-SHIFT of 0x5A+0x3C -> ignored; result 0x96, one done pulse.
//  - start held high in DONE with 0x80+0x80 -> captured back-to-back.
//    - next done 9 cycles later; sum=0x00, cout=1; sum held 0x96 in between.
//  - rst_n low at SHIFT cycle 4, released 2 cycles later:
//    - no done; sum=0, cout=0, ready=1;
//    - next add 0x01+0x01 -> sum=0x02.
//  - WIDTH=2 and WIDTH=64: 1000 random operands each -> all match; done spacing = WIDTH+1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and sizing helper for the serial adder
package serial_adder_pkg;

  // Controller states: waiting for work, adding one bit per clock, result strobe
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Bit count needed to index every bit position of a WIDTH-bit operand
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/fa_cell.sv
// rtl/fa_cell.sv - gate-level 1-bit full adder
module fa_cell (
  output logic s,
  output logic c,
  input  logic a,
  input  logic b,
  input  logic cin
);

  logic p;
  logic g;
  logic t;

  // Propagate/generate form: s = a^b^cin, c = ab | (a^b)cin
  xor u_xor_p (p, a, b);
  xor u_xor_s (s, p, cin);
  and u_and_g (g, a, b);
  and u_and_t (t, p, cin);
  or  u_or_c  (c, g, t);

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial WIDTH-bit adder built around one full-adder cell
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             cell_s;
  logic             cell_c;

  // The single adder cell always looks at the current LSBs and the carry flop
  fa_cell u_fa (
    .s   (cell_s),
    .c   (cell_c),
    .a   (a_sr[0]),
    .b   (b_sr[0]),
    .cin (carry)
  );

  // Controller plus datapath: capture, shift one bit per clock, publish on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ready <= 1'b1;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sr  <= '0;
      b_sr  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // DONE accepts a new start exactly like IDLE so results can stream back-to-back
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= S_SHIFT;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= S_IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        S_SHIFT: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          acc   <= {cell_s, acc[WIDTH-1:1]};
          carry <= cell_c;
          cnt   <= cnt + 1'b1;
          // Last bit: the visible result is updated only here, never with partial sums
          if (cnt == CNT_LAST) begin
            sum   <= {cell_s, acc[WIDTH-1:1]};
            cout  <= cell_c;
            state <= S_DONE;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized and directed checks of serial_adder_ctrl at WIDTH 8, 2 and 64
module tb_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start_v [3];
  logic [63:0] a_v     [3];
  logic [63:0] b_v     [3];
  logic        cin_v   [3];
  logic        ready_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        cout_v  [3];
  logic [63:0] sum_v   [3];
  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [63:0] sum64;

  int          wid [3] = '{8, 2, 64};

  // reference model state: at most one operation in flight per instance
  bit          pend      [3];
  int          pend_edge [3];
  logic [64:0] pend_exp  [3];
  logic [64:0] held      [3];
  int          comp      [3];
  int          dcount    [3];

  int          cyc;
  int          n_pass;
  int          n_total;

  serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
    .cin(cin_v[0]), .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .sum(sum8), .cout(cout_v[0])
  );

  serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a_v[1][1:0]), .b(b_v[1][1:0]),
    .cin(cin_v[1]), .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .sum(sum2), .cout(cout_v[1])
  );

  serial_adder_ctrl #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]),
    .cin(cin_v[2]), .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .sum(sum64), .cout(cout_v[2])
  );

  assign sum_v[0] = 64'(sum8);
  assign sum_v[1] = 64'(sum2);
  assign sum_v[2] = sum64;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [63:0] smask(input int w);
    if (w >= 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  task automatic chk(input string nm, input logic [67:0] act, input logic [67:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // per-cycle model: {cout,sum} = a+b+cin appears WIDTH edges after the accepting edge
  task automatic model_step(input int i);
    logic [67:0] exp;
    logic [67:0] act;
    logic        m_rdy;
    logic        m_bsy;
    logic        m_dn;
    act = {ready_v[i], busy_v[i], done_v[i], cout_v[i], sum_v[i]};
    if (!rst_n) begin
      pend[i] = 1'b0;
      held[i] = '0;
      m_rdy = 1'b1; m_bsy = 1'b0; m_dn = 1'b0;
    end else if (pend[i] && (pend_edge[i] + wid[i] == cyc)) begin
      held[i] = pend_exp[i];
      pend[i] = 1'b0;
      comp[i] = comp[i] + 1;
      m_rdy = 1'b1; m_bsy = 1'b0; m_dn = 1'b1;
    end else if (pend[i]) begin
      m_rdy = 1'b0; m_bsy = 1'b1; m_dn = 1'b0;
    end else begin
      m_rdy = 1'b1; m_bsy = 1'b0; m_dn = 1'b0;
    end
    exp = {m_rdy, m_bsy, m_dn, held[i][wid[i]], held[i][63:0] & smask(wid[i])};
    chk($sformatf("cycle_w%0d_c%0d", wid[i], cyc), act, exp);
    if (rst_n && done_v[i]) dcount[i] = dcount[i] + 1;
    if (rst_n && m_rdy && start_v[i]) begin
      pend[i]      = 1'b1;
      pend_edge[i] = cyc + 1;
      pend_exp[i]  = 65'(a_v[i]) + 65'(b_v[i]) + 65'(cin_v[i]);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) model_step(i);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic present(input logic [7:0] a, input logic [7:0] b, input logic ci);
    start_v[0] = 1'b1;
    a_v[0]     = 64'(a);
    b_v[0]     = 64'(b);
    cin_v[0]   = ci;
  endtask

  task automatic wait_done(output int dc, output bit ok);
    ok = 1'b0;
    dc = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done_v[0]) begin
        ok = 1'b1;
        dc = cyc;
        break;
      end
    end
    chk("wait_done_timeout", 68'(ok), 68'(1));
  endtask

  task automatic do_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic [8:0] exp);
    int ac;
    int dc;
    bit ok;
    present(a, b, ci);
    @(negedge clk);
    ac = cyc;
    tick();
    start_v[0] = 1'b0;
    wait_done(dc, ok);
    chk({nm, "_latency"}, 68'(dc - ac), 68'(9));
    chk(nm, 68'({cout_v[0], sum_v[0][7:0]}), 68'(exp));
  endtask

  task automatic rand_run(input int i, input int nops, input int hold_pct, input int budget);
    int target;
    int n;
    target = comp[i] + nops;
    n = 0;
    while (comp[i] < target && n < budget) begin
      tick();
      start_v[i] = ($urandom_range(99) < hold_pct);
      a_v[i]     = {$urandom, $urandom} & smask(wid[i]);
      b_v[i]     = {$urandom, $urandom} & smask(wid[i]);
      cin_v[i]   = 1'($urandom_range(1));
      n = n + 1;
    end
    start_v[i] = 1'b0;
    chk($sformatf("rand_budget_w%0d", wid[i]), 68'(comp[i] >= target), 68'(1));
  endtask

  initial begin
    int ac;
    int d1;
    int d2;
    int d0;
    bit ok;
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0; cin_v[i] = 1'b0;
      pend[i] = 1'b0; pend_edge[i] = 0; pend_exp[i] = '0; held[i] = '0;
      comp[i] = 0; dcount[i] = 0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", 68'({ready_v[0], busy_v[0], done_v[0], cout_v[0], sum_v[0]}),
        {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});

    // single add with documented latency
    tick();
    do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 9'h096);
    tick();
    do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
    tick();
    do_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF);

    // start re-pulsed mid-shift must be ignored
    tick();
    d0 = dcount[0];
    present(8'h5A, 8'h3C, 1'b0);
    tick();
    start_v[0] = 1'b0;
    repeat (3) tick();
    present(8'h11, 8'h22, 1'b0);
    tick();
    start_v[0] = 1'b0;
    wait_done(d1, ok);
    chk("repulse_sum", 68'({cout_v[0], sum_v[0][7:0]}), 68'(9'h096));
    repeat (12) tick();
    chk("repulse_one_done", 68'(dcount[0] - d0), 68'(1));

    // start held through DONE captures the next operands back-to-back
    present(8'h5A, 8'h3C, 1'b0);
    tick();
    a_v[0] = 64'h80;
    b_v[0] = 64'h80;
    wait_done(d1, ok);
    chk("b2b_first", 68'({cout_v[0], sum_v[0][7:0]}), 68'(9'h096));
    tick();
    start_v[0] = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("b2b_hold", 68'({ready_v[0], busy_v[0], done_v[0], cout_v[0], sum_v[0][7:0]}),
        68'({1'b0, 1'b1, 1'b0, 9'h096}));
    wait_done(d2, ok);
    chk("b2b_spacing", 68'(d2 - d1), 68'(9));
    chk("b2b_second", 68'({cout_v[0], sum_v[0][7:0]}), 68'(9'h100));

    // reset in the middle of a shift aborts without a done pulse
    tick();
    present(8'h5A, 8'h3C, 1'b0);
    tick();
    start_v[0] = 1'b0;
    repeat (3) tick();
    d0 = dcount[0];
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset_mid_in", 68'({ready_v[0], busy_v[0], done_v[0], cout_v[0], sum_v[0]}),
        {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
    tick();
    tick();
    rst_n = 1'b1;
    repeat (12) tick();
    chk("reset_no_done", 68'(dcount[0] - d0), 68'(0));
    @(negedge clk);
    chk("reset_after", 68'({ready_v[0], busy_v[0], done_v[0], cout_v[0], sum_v[0]}),
        {1'b1, 1'b0, 1'b0, 1'b0, 64'h0});
    tick();
    do_op("add_01_01", 8'h01, 8'h01, 1'b0, 9'h002);

    // randomized streams on all three widths in parallel
    fork
      rand_run(0, 200, 70, 6000);
      rand_run(1, 1000, 60, 8000);
      rand_run(2, 1000, 100, 70000);
    join
    repeat (80) tick();
    for (int i = 0; i < 3; i++)
      chk($sformatf("done_count_w%0d", wid[i]), 68'(dcount[i]), 68'(comp[i]));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
